// File: rtl/seg_writer_pkg.sv
// Shared types and constants for the 7-segment Avalon writer.
// Imported by the writer top and its BCD converter.
package seg_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE,
    DONE
  } state_t;

  localparam int          NUM_DIGITS      = 6;
  localparam logic [23:0] MAX_DEC         = 24'd999999;
  localparam int          DD_CYCLES       = 24;
  localparam logic [7:0]  BLANK_CODE_DFLT = 8'h10;

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: 24-bit binary to 6 BCD digits.
// One shift per cycle; done is high during the final shift cycle.
module bin_to_bcd_seq
  import seg_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] bin,
  output logic [23:0] bcd,
  output logic        done
);

  logic [23:0] sh;
  logic [23:0] bcd_q;
  logic [23:0] adj;
  logic [4:0]  cnt;
  logic        active;

  // add 3 to every nibble >= 5 ahead of the shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // load on start, then shift one bit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh     <= bin;
      bcd_q  <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      bcd_q <= {adj[22:0], sh[23]};
      sh    <= {sh[22:0], 1'b0};
      cnt   <= cnt + 5'd1;
      if (cnt == 5'(DD_CYCLES - 1))
        active <= 1'b0;
    end
  end

  assign bcd  = bcd_q;
  assign done = active && (cnt == 5'(DD_CYCLES - 1));

endmodule

// File: rtl/avalon_seg_writer.sv
// Avalon-MM master that writes a 24-bit value as six digit bytes.
// Decimal values go through a double-dabble; hex writes nibbles.
module avalon_seg_writer
  import seg_writer_pkg::*;
#(
  parameter int         NUM_DIGITS = seg_writer_pkg::NUM_DIGITS,
  parameter int         BLANK_LZ   = 1,
  parameter logic [7:0] BLANK_CODE = BLANK_CODE_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] value_i,
  input  logic        hex_mode_i,
  input  logic        start_valid_i,
  output logic        start_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [2:0]  avm_address_o,
  output logic        avm_write_o,
  output logic [7:0]  avm_writedata_o,
  input  logic        avm_waitrequest_i
);

  state_t          state;
  logic            hex_q;
  logic [23:0]     val_q;
  logic [23:0]     sat;
  logic [23:0]     bcd;
  logic            bcd_done;
  logic            accept;
  logic [23:0]     src;
  logic [NUM_DIGITS-1:0] keep;
  logic            acc;
  logic [3:0]      dig;

  assign accept = start_valid_i && start_ready_o;
  assign sat    = (value_i > MAX_DEC) ? MAX_DEC : value_i;

  bin_to_bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept && !hex_mode_i),
    .bin   (sat),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // digit k survives blanking if any digit at or above k is nonzero
  always_comb begin
    src  = hex_q ? val_q : bcd;
    acc  = 1'b0;
    keep = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      acc     = acc | (src[4*j +: 4] != 4'h0);
      keep[j] = acc || (j == 0);
    end
  end

  // writedata follows the registered address and held digits
  always_comb begin
    dig = src[4*avm_address_o +: 4];
    if (!avm_write_o)
      avm_writedata_o = 8'h00;
    else if ((BLANK_LZ != 0) && !keep[avm_address_o])
      avm_writedata_o = BLANK_CODE;
    else
      avm_writedata_o = {4'h0, dig};
  end

  // control FSM with registered handshake and bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      start_ready_o <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      ovf_o         <= 1'b0;
      avm_write_o   <= 1'b0;
      avm_address_o <= '0;
      hex_q         <= 1'b0;
      val_q         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (accept) begin
            hex_q         <= hex_mode_i;
            val_q         <= value_i;
            start_ready_o <= 1'b0;
            busy_o        <= 1'b1;
            avm_address_o <= '0;
            if (hex_mode_i) begin
              ovf_o       <= 1'b0;
              avm_write_o <= 1'b1;
              state       <= WRITE;
            end else begin
              ovf_o <= (value_i > MAX_DEC);
              state <= CONVERT;
            end
          end
        end
        CONVERT: begin
          if (bcd_done) begin
            avm_write_o   <= 1'b1;
            avm_address_o <= '0;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest_i) begin
            if (avm_address_o == 3'(NUM_DIGITS - 1)) begin
              avm_write_o   <= 1'b0;
              avm_address_o <= '0;
              busy_o        <= 1'b0;
              done_o        <= 1'b1;
              state         <= DONE;
            end else begin
              avm_address_o <= avm_address_o + 3'd1;
            end
          end
        end
        DONE: begin
          done_o        <= 1'b0;
          start_ready_o <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/avalon_seg_writer.md
Name: avalon_seg_writer

Overview:
- Avalon-MM master stage that sits directly upstream of the six-digit 7-segment Avalon slave (3-bit address, 8-bit writedata, one byte per digit).
- Accepts a 24-bit value over a valid/ready handshake.
- In decimal mode, converts the value to 6 BCD digits with a sequential double-dabble.
- Then issues six single-beat Avalon writes, one per digit, at addresses 0..5.
- Optionally blanks leading zeros.

Parameters:
- NUM_DIGITS, 6, digit count and number of writes per update (fixed at 6 for this revision).
- BLANK_LZ, 1, when 1, leading-zero digits are written as BLANK_CODE.
- BLANK_CODE, 8'h10, writedata byte meaning "segment off" to the downstream slave.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- value_i  in  24  value to display
- hex_mode_i  in  1  1 = show value_i as 6 hex nibbles; 0 = decimal
- start_valid_i  in  1  request valid
- start_ready_o  out  1  block can accept a request
- busy_o  out  1  conversion or write sequence in progress
- done_o  out  1  one-cycle pulse after the last digit write is accepted
- ovf_o  out  1  decimal value exceeded 999999 and was saturated (sticky until next accept)
- avm_address_o  out  3  digit address, 0 = least significant digit
- avm_write_o  out  1  write strobe
- avm_writedata_o  out  8  {4'h0, digit} or BLANK_CODE
- avm_waitrequest_i  in  1  slave stall; tie to 0 when the slave has none

Behaviour:
- Reset: one clock with rst high forces all outputs and state to their reset values.
  - State IDLE, start_ready_o=1, busy_o=0, done_o=0, ovf_o=0.
  - avm_write_o=0, avm_address_o=0, avm_writedata_o=0.
  - Reset mid-sequence aborts immediately. Partial digit writes already issued are not undone.
- FSM states: IDLE, CONVERT, WRITE, DONE.
- IDLE: start_ready_o=1. On start_valid_i && start_ready_o, capture value_i and hex_mode_i. ovf_o is cleared/set on this capture.
  - Decimal capture: if value_i > 999999, capture 999999 and set ovf_o, else clear ovf_o.
  - Hex capture: ovf_o=0.
  - Next state: CONVERT if decimal, WRITE if hex.
- CONVERT: exactly 24 cycles, one double-dabble shift per cycle.
  - Before each shift, add 3 to any BCD nibble >= 5.
  - Result is a 24-bit register of 6 BCD digits.
  - After the 24th cycle go to WRITE.
- WRITE: digit index k runs 0..5.
  - Drive avm_write_o=1, avm_address_o=k, avm_writedata_o=digit k (or BLANK_CODE).
  - A beat is accepted on a cycle with avm_write_o=1 and avm_waitrequest_i=0. k then increments.
  - While waitrequest is high, address, writedata and write stay stable.
  - After the beat for k=5 is accepted, go to DONE. avm_write_o drops in DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE.
  - start_ready_o is 0 in DONE; it returns in IDLE on the next cycle.
- busy_o=1 in CONVERT and WRITE. start_ready_o=0 in every state except IDLE.
- Leading-zero blanking (BLANK_LZ=1): digit k is blanked iff k>0 and all digits j>=k are zero.
  - Digit 0 is never blanked, so value 0 displays "0".
  - The rule applies in both modes.
- Latency with no waitrequest:
  - Decimal: accept at cycle T, CONVERT T+1..T+24, writes T+25..T+30, done_o at T+31.
  - Hex: writes T+1..T+6, done_o at T+7.
- start_valid_i asserted while busy is ignored; there is no queueing.
- Hex digits use nibble k = value_i[4k+3:4k]. Decimal digits are the BCD nibbles, same ordering.

Decomposition:
- Package seg_writer_pkg holds:
  - state enum (IDLE, CONVERT, WRITE, DONE)
  - NUM_DIGITS=6
  - MAX_DEC=24'd999999
  - DD_CYCLES=24
  - BLANK_CODE default
- One sub-module: bin_to_bcd_seq.
  - Interface: start pulse, 24-bit binary in, 24-bit BCD out, done pulse.
  - Sequential double-dabble, 24 cycles; the FSM waits on its done.
- Blanking and the Avalon beat logic stay in the top module.

Test Plan:
- Decimal 123456, waitrequest=0:
  - Writes addr0..5 = 8'h06,05,04,03,02,01 at T+25..T+30.
  - done_o pulses at T+31; ovf_o=0.
- Hex 24'hABC012, hex_mode=1, BLANK_LZ=1:
  - Writes addr0..5 = 02,01,00,0C,0B,0A at T+1..T+6.
  - The 00 at addr2 is not blanked (higher digits are nonzero).
- Decimal 42, BLANK_LZ=1 -> writes 02,04,10,10,10,10. Decimal 0 -> writes 00,10,10,10,10,10.
- Decimal 24'hFFFFFF -> ovf_o=1; writes 09 x6. Next request of 5 -> ovf_o clears at accept.
- waitrequest high for 3 cycles during the addr2 beat:
  - addr/data/write stay stable throughout.
  - Sequence completes 3 cycles later; start_valid_i pulsed while busy is ignored (start_ready_o=0).
- rst asserted during CONVERT and during WRITE (addr3):
  - Next cycle: avm_write_o=0, start_ready_o=1, busy_o=0.
  - A fresh request then completes normally.
